// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the packet stream demultiplexer.
package stream_demux_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUTE = 2'd1,
      DROP  = 2'd2
   } state_e;

   // Low bit index of output lane ch in a flat lane-packed bus.
   function automatic int lane_lo(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/stream_demux_1n.sv
// Registered 1:N packet demultiplexer with valid/ready on every stream.
// The channel is latched on the first beat of a packet; packets addressed
// past the last channel are swallowed and counted.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for the first beat of a packet; s_sel is decoded
//   ROUTE | packet open, beats go to the latched channel, s_sel ignored
//   DROP  | packet addressed out of range, beats accepted and discarded
module stream_demux_1n
   import stream_demux_pkg::*;
#(
   parameter int N_OUT  = 8,
   parameter int DATA_W = 8,
   parameter int SEL_W  = $clog2(N_OUT) + 1,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_W-1:0]         s_data,
   input  logic [SEL_W-1:0]          s_sel,
   input  logic                      s_last,
   output logic [N_OUT-1:0]          m_valid,
   input  logic [N_OUT-1:0]          m_ready,
   output logic [N_OUT*DATA_W-1:0]   m_data,
   output logic [N_OUT-1:0]          m_last,
   output logic                      drop_pkt,
   output logic [CNT_W-1:0]          drop_cnt
);

   localparam int               CH_W      = $clog2(N_OUT);
   localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(N_OUT);

   state_e             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic [CH_W-1:0]    out_ch_q, out_ch_d;
   logic               drop_pkt_q, drop_pkt_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic [N_OUT-1:0]   ch_hot;
   logic               drain;
   logic               sel_oor;
   logic               accept;

   // Lane fan-out: only the held channel sees the register, others read 0.
   for (genvar i = 0; i < N_OUT; i++) begin : g_lane
      assign ch_hot[i]  = (out_ch_q == CH_W'(i));
      assign m_valid[i] = out_valid_q & ch_hot[i];
      assign m_last[i]  = m_valid[i] & out_last_q;
      assign m_data[lane_lo(i, DATA_W) +: DATA_W] = m_valid[i] ? out_data_q : '0;
   end

   // Ready of the currently held channel; decoded one-hot so a non power of
   // two N_OUT never indexes past the ready vector.
   assign drain    = |(ch_hot & m_ready);
   assign sel_oor  = (s_sel >= SEL_LIMIT);
   assign s_ready  = (state_q == DROP) | ((state_q == IDLE) & sel_oor) |
                     ~out_valid_q | drain;
   assign accept   = s_valid & s_ready;
   assign drop_pkt = drop_pkt_q;
   assign drop_cnt = drop_cnt_q;

   // Next-state, output register load and drop accounting.
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      out_valid_d = out_valid_q & ~drain;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      drop_pkt_d  = 1'b0;
      drop_cnt_d  = drop_cnt_q;
      if (accept) begin
         unique case (state_q)
            IDLE: begin
               if (sel_oor) begin
                  drop_pkt_d = 1'b1;
                  if (drop_cnt_q != '1) begin
                     drop_cnt_d = drop_cnt_q + CNT_W'(1);
                  end
                  state_d = s_last ? IDLE : DROP;
               end else begin
                  ch_d        = s_sel[CH_W-1:0];
                  out_valid_d = 1'b1;
                  out_data_d  = s_data;
                  out_last_d  = s_last;
                  out_ch_d    = s_sel[CH_W-1:0];
                  state_d     = s_last ? IDLE : ROUTE;
               end
            end
            ROUTE: begin
               out_valid_d = 1'b1;
               out_data_d  = s_data;
               out_last_d  = s_last;
               out_ch_d    = ch_q;
               if (s_last) begin
                  state_d = IDLE;
               end
            end
            DROP: begin
               if (s_last) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset wins over any handshake in the cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
         drop_pkt_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
         drop_pkt_q  <= drop_pkt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_stream_demux_1n.sv
// Directed bench for stream_demux_1n: a default instance and a CNT_W=2
// instance share all inputs so counter saturation can be observed.
module tb_stream_demux_1n;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic [7:0]  s_data;
   logic [3:0]  s_sel;
   logic        s_last;
   logic [7:0]  m_ready;

   logic        s_ready, s_ready_c2;
   logic [7:0]  m_valid, m_valid_c2;
   logic [63:0] m_data, m_data_c2;
   logic [7:0]  m_last, m_last_c2;
   logic        drop_pkt, drop_pkt_c2;
   logic [15:0] drop_cnt;
   logic [1:0]  drop_cnt_c2;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stream_demux_1n #(.N_OUT(8), .DATA_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .drop_pkt(drop_pkt), .drop_cnt(drop_cnt)
   );

   stream_demux_1n #(.N_OUT(8), .DATA_W(8), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_c2),
      .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
      .m_valid(m_valid_c2), .m_ready(m_ready), .m_data(m_data_c2), .m_last(m_last_c2),
      .drop_pkt(drop_pkt_c2), .drop_cnt(drop_cnt_c2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] sel, input logic [7:0] d, input logic l);
      s_valid = v;
      s_sel   = sel;
      s_data  = d;
      s_last  = l;
   endtask

   function automatic logic [63:0] lane(input int ch, input logic [7:0] d);
      logic [63:0] w;
      w = 64'(d);
      return w << (8 * ch);
   endfunction

   initial begin
      logic [7:0] oh;
      logic [7:0] d;
      rst = 1'b1;
      m_ready = 8'hFF;
      drive(1'b0, 4'd0, 8'h00, 1'b0);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_vld",  m_valid, 0);
      chk("rst_dat",  m_data, 0);
      chk("rst_lst",  m_last, 0);
      chk("rst_drop", drop_pkt, 0);
      chk("rst_cnt",  drop_cnt, 0);
      chk("rst_rdy",  s_ready, 1);

      // 1: 3-beat packets to each channel, full rate.
      for (int k = 0; k < 8; k++) begin
         for (int b = 0; b < 3; b++) begin
            d  = 8'hA0 + 8'(k);
            oh = 8'd1 << k;
            drive(1'b1, 4'(k), d, b == 2);
            #1;
            chk("t1_rdy", s_ready, 1);
            step();
            chk("t1_vld", m_valid, oh);
            chk("t1_dat", m_data, lane(k, d));
            chk("t1_lst", m_last, (b == 2) ? oh : 8'h00);
         end
      end
      drive(1'b0, 4'd0, 8'h00, 1'b0);
      step();
      chk("t1_idle", m_valid, 0);

      // 2: backpressure on ch5 mid-packet.
      drive(1'b1, 4'd5, 8'h50, 1'b0);
      step();
      chk("t2_b0", m_data, lane(5, 8'h50));
      m_ready = 8'hDF;
      drive(1'b1, 4'd5, 8'h51, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_stall_rdy", s_ready, 0);
         step();
         chk("t2_stall_vld", m_valid, 8'h20);
         chk("t2_stall_dat", m_data, lane(5, 8'h50));
      end
      m_ready = 8'hFF;
      #1;
      chk("t2_rel_rdy", s_ready, 1);
      step();
      chk("t2_b1", m_data, lane(5, 8'h51));
      drive(1'b1, 4'd5, 8'h52, 1'b1);
      step();
      chk("t2_b2", m_data, lane(5, 8'h52));
      chk("t2_lst", m_last, 8'h20);
      drive(1'b0, 4'd0, 8'h00, 1'b0);
      step();
      chk("t2_idle", m_valid, 0);

      // 3: out-of-range packet dropped while ch0 holds a stalled beat.
      drive(1'b1, 4'd0, 8'h0F, 1'b1);
      step();
      m_ready = 8'h00;
      drive(1'b1, 4'd9, 8'h90, 1'b0);
      #1;
      chk("t3_rdy0", s_ready, 1);
      step();
      chk("t3_pulse", drop_pkt, 1);
      chk("t3_cnt", drop_cnt, 1);
      chk("t3_vld0", m_valid, 8'h01);
      drive(1'b1, 4'd9, 8'h91, 1'b1);
      #1;
      chk("t3_rdy1", s_ready, 1);
      step();
      chk("t3_nopulse", drop_pkt, 0);
      chk("t3_cnt1", drop_cnt, 1);
      chk("t3_held", m_data, lane(0, 8'h0F));
      m_ready = 8'hFF;
      drive(1'b0, 4'd0, 8'h00, 1'b0);
      step();
      chk("t3_idle", m_valid, 0);

      // 4: select changes mid-packet are ignored; next packet goes to ch6.
      drive(1'b1, 4'd2, 8'h20, 1'b0);
      step();
      chk("t4_b0", m_data, lane(2, 8'h20));
      drive(1'b1, 4'd6, 8'h21, 1'b0);
      step();
      chk("t4_b1", m_data, lane(2, 8'h21));
      drive(1'b1, 4'd6, 8'h22, 1'b1);
      step();
      chk("t4_b2", m_valid, 8'h04);
      chk("t4_b2l", m_last, 8'h04);
      m_ready = 8'hFB;
      drive(1'b1, 4'd6, 8'h60, 1'b1);
      #1;
      chk("t4_oldch_busy", s_ready, 0);
      m_ready = 8'h04;
      #1;
      chk("t4_oldch_rdy", s_ready, 1);
      step();
      chk("t4_new_vld", m_valid, 8'h40);
      chk("t4_new_dat", m_data, lane(6, 8'h60));
      chk("t4_new_lst", m_last, 8'h40);
      m_ready = 8'hFF;
      drive(1'b0, 4'd0, 8'h00, 1'b0);
      step();
      chk("t4_idle", m_valid, 0);

      // 5: reset with a stalled beat and an open packet.
      drive(1'b1, 4'd3, 8'h30, 1'b0);
      step();
      m_ready = 8'h00;
      drive(1'b1, 4'd3, 8'h31, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 4'd0, 8'h00, 1'b0);
      m_ready = 8'hFF;
      #1;
      chk("t5_vld", m_valid, 0);
      chk("t5_dat", m_data, 0);
      chk("t5_cnt", drop_cnt, 0);
      drive(1'b1, 4'd1, 8'h11, 1'b1);
      step();
      chk("t5_vld1", m_valid, 8'h02);
      chk("t5_dat1", m_data, lane(1, 8'h11));
      drive(1'b0, 4'd0, 8'h00, 1'b0);
      step();

      // 6: five back-to-back single-beat drops; CNT_W=2 saturates at 3.
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 4'd15, 8'(k), 1'b1);
         #1;
         chk("t6_rdy", s_ready, 1);
         step();
         chk("t6_pulse", drop_pkt_c2, 1);
         chk("t6_cnt2", drop_cnt_c2, (k + 1 > 3) ? 3 : k + 1);
         chk("t6_cnt16", drop_cnt, k + 1);
         chk("t6_vld", m_valid, 0);
      end
      drive(1'b0, 4'd0, 8'h00, 1'b0);
      step();
      chk("t6_nopulse", drop_pkt_c2, 0);
      chk("t6_hold", drop_cnt_c2, 3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
